// File: rtl/i2c_bus_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_bus_sequencer
//   I2C subordinate front end that sits in front of the address checker.
//   - Synchronises raw SCL/SDA and glitch-filters them.
//   - Detects START, repeated START and STOP conditions.
//   - Tracks the bit index within a byte and whether the address byte is on
//     the bus.
//   - Uses the checker's address_match to drive the ACK slot and to pick the
//     frame state.
//
// Ports
//   i_clk            system clock (at least 8x the SCL rate)
//   i_rst_n          asynchronous active-low reset
//   i_scl_in         raw SCL from pad
//   i_sda_in         raw SDA from pad
//   i_address_match  checker result, valid after the R/W bit SCL rise
//   i_ack_en         1 = ACK data bytes while in DATA
//   o_scl_f          filtered SCL
//   o_sda_f          filtered SDA
//   o_scl_rise       1-cycle pulse on an o_scl_f rising edge
//   o_scl_fall       1-cycle pulse on an o_scl_f falling edge
//   o_start_det      1-cycle pulse on START or repeated START
//   o_stop_det       1-cycle pulse on STOP
//   o_clock_count    bit index in the byte: 0..7 data bits, 8 = ACK slot
//   o_read_address   1 while the address byte (bits 0..7) is on the bus
//   o_byte_done      1-cycle pulse on the SCL fall that ends the ACK slot
//   o_sda_ack_low    1 = pad pulls SDA low (ACK)
//   o_busy           1 while the sequencer is not idle
// ---------------------------------------------------------------------------
module i2c_bus_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl_in,
  input  logic       i_sda_in,
  input  logic       i_address_match,
  input  logic       i_ack_en,
  output logic       o_scl_f,
  output logic       o_sda_f,
  output logic       o_scl_rise,
  output logic       o_scl_fall,
  output logic       o_start_det,
  output logic       o_stop_det,
  output logic [3:0] o_clock_count,
  output logic       o_read_address,
  output logic       o_byte_done,
  output logic       o_sda_ack_low,
  output logic       o_busy
);

  // Counter only has to hold 0..FILTER_LEN-1.
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {i_sda_in, i_scl_in};

  // Synchroniser followed by a run-length filter: the output only follows
  // the synced line after FILTER_LEN consecutive samples that disagree with it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CW-1:0]          r_cnt;
      logic                   r_filt;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_sync <= '1;
          r_cnt  <= '0;
          r_filt <= 1'b1;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
          if (r_sync[SYNC_STAGES-1] == r_filt) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_filt <= r_sync[SYNC_STAGES-1];
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_filt[gi] = r_filt;
    end
  endgenerate

  logic   r_scl_d, r_sda_d;
  logic   r_scl_rise, r_scl_fall, r_start, r_stop, r_byte_done;
  logic   r_read_address, r_busy, r_first_fall, r_match, r_ack_low;
  logic   [3:0] r_count;
  state_t r_state;

  logic   w_scl_rise, w_scl_fall, w_scl_hold, w_start, w_stop;
  logic   w_first_next, w_match_next, w_ack_next, w_byte_done_next;
  logic   [3:0] w_count_next;
  state_t w_state_next;

  assign w_scl_rise = w_filt[0] & ~r_scl_d;
  assign w_scl_fall = ~w_filt[0] & r_scl_d;
  // START/STOP need SCL high on both sides of the SDA edge; a simultaneous
  // SCL edge therefore masks the SDA edge.
  assign w_scl_hold = w_filt[0] & r_scl_d;
  assign w_start    = w_scl_hold & r_sda_d & ~w_filt[1];
  assign w_stop     = w_scl_hold & ~r_sda_d & w_filt[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_count        <= 4'd0;
      r_first_fall   <= 1'b0;
      r_match        <= 1'b0;
      r_ack_low      <= 1'b0;
      r_byte_done    <= 1'b0;
      r_read_address <= 1'b0;
      r_busy         <= 1'b0;
      r_scl_d        <= 1'b1;
      r_sda_d        <= 1'b1;
      r_scl_rise     <= 1'b0;
      r_scl_fall     <= 1'b0;
      r_start        <= 1'b0;
      r_stop         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_count        <= w_count_next;
      r_first_fall   <= w_first_next;
      r_match        <= w_match_next;
      r_ack_low      <= w_ack_next;
      r_byte_done    <= w_byte_done_next;
      r_read_address <= (w_state_next == ST_ADDR) && (w_count_next <= 4'd7);
      r_busy         <= (w_state_next != ST_IDLE);
      r_scl_d        <= w_filt[0];
      r_sda_d        <= w_filt[1];
      r_scl_rise     <= w_scl_rise;
      r_scl_fall     <= w_scl_fall;
      r_start        <= w_start;
      r_stop         <= w_stop;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_first_next     = r_first_fall;
    w_match_next     = r_match;
    w_ack_next       = r_ack_low;
    w_byte_done_next = 1'b0;

    if (w_stop) begin
      w_state_next = ST_IDLE;
      w_count_next = 4'd0;
      w_first_next = 1'b0;
      w_match_next = 1'b0;
      w_ack_next   = 1'b0;
    end else if (w_start) begin
      w_state_next = ST_ADDR;
      w_count_next = 4'd0;
      w_first_next = 1'b1;
      w_match_next = 1'b0;
      w_ack_next   = 1'b0;
    end else if (w_scl_fall && (r_state != ST_IDLE)) begin
      if (r_first_fall) begin
        // This fall belongs to the START condition, not to a data bit.
        w_first_next = 1'b0;
      end else if (r_count == 4'd8) begin
        w_count_next     = 4'd0;
        w_byte_done_next = 1'b1;
        w_ack_next       = 1'b0;
        if (r_state == ST_ADDR) begin
          w_state_next = r_match ? ST_DATA : ST_IGNORE;
        end
      end else begin
        w_count_next = r_count + 4'd1;
        // The fall after bit 7 opens the ACK slot: decide the ACK now.
        if (r_count == 4'd7) begin
          if (r_state == ST_ADDR) begin
            w_match_next = i_address_match;
            w_ack_next   = i_address_match;
          end else if (r_state == ST_DATA) begin
            w_ack_next = i_ack_en;
          end else begin
            w_ack_next = 1'b0;
          end
        end
      end
    end
  end

  assign o_scl_f        = w_filt[0];
  assign o_sda_f        = w_filt[1];
  assign o_scl_rise     = r_scl_rise;
  assign o_scl_fall     = r_scl_fall;
  assign o_start_det    = r_start;
  assign o_stop_det     = r_stop;
  assign o_clock_count  = r_count;
  assign o_read_address = r_read_address;
  assign o_byte_done    = r_byte_done;
  assign o_sda_ack_low  = r_ack_low;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_i2c_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_sequencer
//   Drives I2C bus activity at the byte/bit level and predicts every
//   SCL edge, START and STOP event the sequencer should report, together
//   with the frame status seen right after that event. A monitor pops the
//   prediction whenever the DUT pulses an event and compares.
// ---------------------------------------------------------------------------
module tb_i2c_bus_sequencer;
  localparam int         SYNC_STAGES = 2;
  localparam int         FILTER_LEN  = 3;
  localparam int         Q           = 8;      // clk cycles per quarter SCL period
  localparam logic [6:0] MY_ADDR     = 7'h67;  // address the checker answers to

  localparam logic [3:0] P_START = 4'b1000;
  localparam logic [3:0] P_STOP  = 4'b0100;
  localparam logic [3:0] P_RISE  = 4'b0010;
  localparam logic [3:0] P_FALL  = 4'b0001;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       scl    = 1'b1;
  logic       sda    = 1'b1;
  logic       amatch = 1'b0;
  logic       acken  = 1'b0;

  logic       o_scl_f, o_sda_f, o_scl_rise, o_scl_fall, o_start_det, o_stop_det;
  logic [3:0] o_clock_count;
  logic       o_read_address, o_byte_done, o_sda_ack_low, o_busy;

  i2c_bus_sequencer #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_scl_in        (scl),
    .i_sda_in        (sda),
    .i_address_match (amatch),
    .i_ack_en        (acken),
    .o_scl_f         (o_scl_f),
    .o_sda_f         (o_sda_f),
    .o_scl_rise      (o_scl_rise),
    .o_scl_fall      (o_scl_fall),
    .o_start_det     (o_start_det),
    .o_stop_det      (o_stop_det),
    .o_clock_count   (o_clock_count),
    .o_read_address  (o_read_address),
    .o_byte_done     (o_byte_done),
    .o_sda_ack_low   (o_sda_ack_low),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pulses;  // {start, stop, rise, fall}
    logic [3:0] count;
    logic       rd;
    logic       ack;
    logic       busy;
    logic       bdone;
  } ev_t;

  ev_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Frame model: phase 0 idle, 1 address byte, 2 data (matched), 3 ignored.
  int   m_phase = 0;
  int   m_count = 0;
  logic m_ack   = 1'b0;
  logic m_match = 1'b0;

  function automatic logic rbit();
    logic [31:0] r;
    r = $urandom();
    return r[0];
  endfunction

  function automatic string fmt(input ev_t x);
    return $sformatf("pulses(start,stop,rise,fall)=%b count=%0d rd=%b ack=%b busy=%b byte_done=%b",
                     x.pulses, x.count, x.rd, x.ack, x.busy, x.bdone);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, got, req);
    end else begin
      $display("[TB] check %s ok (0x%0h)", name, got);
    end
  endtask

  // Predict the status the DUT should show right after the event.
  task automatic ev(input logic [3:0] p, input logic bd);
    ev_t e;
    e.pulses = p;
    e.count  = 4'(m_count);
    e.rd     = (m_phase == 1) && (m_count <= 7);
    e.ack    = m_ack;
    e.busy   = (m_phase != 0);
    e.bdone  = bd;
    exp_q.push_back(e);
  endtask

  // One bit: SDA set while SCL low, then a full SCL pulse. last=1 marks the
  // 8th bit, whose falling edge opens the ACK slot.
  task automatic send_bit(input logic b, input logic last);
    sda = b;
    tick(Q);
    scl = 1'b1;
    ev(P_RISE, 1'b0);
    tick(2 * Q);
    scl = 1'b0;
    if (m_phase != 0) m_count++;
    if (last) begin
      if (m_phase == 1)      m_ack = m_match;
      else if (m_phase == 2) m_ack = acken;
      else                   m_ack = 1'b0;
    end
    ev(P_FALL, 1'b0);
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int nbits, input logic ackv);
    acken = ackv;
    for (int j = 0; j < nbits; j++) begin
      // The match input is junk except once the R/W bit of the address is out.
      if (m_phase == 1 && j == 7) amatch = m_match;
      else                        amatch = rbit();
      send_bit(d[7-j], (j == 7));
    end
  endtask

  task automatic ack_slot();
    sda = 1'b1;
    tick(Q);
    scl = 1'b1;
    ev(P_RISE, 1'b0);
    tick(2 * Q);
    scl = 1'b0;
    m_count = 0;
    m_ack   = 1'b0;
    if (m_phase == 1) m_phase = m_match ? 2 : 3;
    ev(P_FALL, 1'b1);
    tick(Q);
  endtask

  task automatic send_addr(input logic [6:0] addr, input logic rw);
    m_match = (addr == MY_ADDR);
    send_byte({addr, rw}, 8, rbit());
    ack_slot();
  endtask

  // START from an idle bus, or repeated START when SCL is currently low.
  task automatic do_start(input logic measure);
    int  n;
    logic seen;
    if (scl == 1'b0) begin
      sda = 1'b1;
      tick(Q);
      scl = 1'b1;
      ev(P_RISE, 1'b0);
      tick(Q);
    end
    m_phase = 1;
    m_count = 0;
    m_ack   = 1'b0;
    ev(P_START, 1'b0);
    sda = 1'b0;
    if (measure) begin
      seen = 1'b0;
      n    = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
        @(posedge clk);
        #1;
        if (o_start_det) begin
          seen = 1'b1;
          n    = k;
        end
      end
      check("start_latency", n, SYNC_STAGES + FILTER_LEN + 1);
    end
    tick(Q);
    scl = 1'b0;
    ev(P_FALL, 1'b0);
    tick(Q);
  endtask

  task automatic do_stop();
    sda = 1'b0;
    tick(Q);
    scl = 1'b1;
    ev(P_RISE, 1'b0);
    tick(Q);
    m_phase = 0;
    m_count = 0;
    m_ack   = 1'b0;
    ev(P_STOP, 1'b0);
    sda = 1'b1;
    tick(2 * Q);
  endtask

  task automatic monitor();
    ev_t a;
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (o_start_det | o_stop_det | o_scl_rise | o_scl_fall | o_byte_done)) begin
        a.pulses = {o_start_det, o_stop_det, o_scl_rise, o_scl_fall};
        a.count  = o_clock_count;
        a.rd     = o_read_address;
        a.ack    = o_sda_ack_low;
        a.busy   = o_busy;
        a.bdone  = o_byte_done;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event got %s required none", fmt(a));
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL event got %s required %s", fmt(a), fmt(e));
          end else begin
            $display("[TB] event %s", fmt(a));
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    logic low_seen;
    int   nbytes, tail;
    logic rs;
    logic [6:0] addr;
    logic [31:0] r;

    // Reset with both pads low: filters must still come up high.
    rst_n = 1'b0;
    scl   = 1'b0;
    sda   = 1'b0;
    tick(5);
    check("reset_outputs",
          {o_scl_f, o_sda_f, o_scl_rise, o_scl_fall, o_start_det, o_stop_det,
           o_clock_count, o_read_address, o_byte_done, o_sda_ack_low, o_busy},
          14'b11_0000_0000_0000);
    scl = 1'b1;
    sda = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(2 * Q);

    // Short SDA glitches while SCL is high must be swallowed.
    for (int g = 1; g <= 2; g++) begin
      sda = 1'b0;
      tick(g);
      sda = 1'b1;
      low_seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
        tick(1);
        if (o_sda_f !== 1'b1) low_seen = 1'b1;
      end
      check($sformatf("glitch_%0dclk_sda_f_low", g), low_seen, 1'b0);
    end

    // Matched write, then one ACKed and one NACKed data byte.
    do_start(1'b1);
    send_addr(7'h67, 1'b0);
    send_byte(8'hA5, 8, 1'b1);
    ack_slot();
    send_byte(8'h3C, 8, 1'b0);
    ack_slot();
    do_stop();

    // Unmatched address: no ACK anywhere, even with ack_en set.
    do_start(1'b0);
    send_addr(7'h12, 1'b0);
    send_byte(8'hFF, 8, 1'b1);
    ack_slot();
    do_stop();

    // Repeated START after bit 3 of a data byte, then STOP.
    do_start(1'b0);
    send_addr(7'h67, 1'b1);
    send_byte(8'hC3, 4, 1'b1);
    do_start(1'b0);
    send_addr(7'h67, 1'b0);
    do_stop();

    // Reset in the middle of an address byte, then SCL activity without START.
    do_start(1'b0);
    m_match = 1'b1;
    send_byte(8'hCE, 5, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_midframe",
          {o_scl_f, o_sda_f, o_busy, o_clock_count, o_sda_ack_low, o_read_address},
          9'b110000000);
    scl = 1'b1;
    sda = 1'b1;
    tick(3);
    rst_n   = 1'b1;
    m_phase = 0;
    m_count = 0;
    m_ack   = 1'b0;
    tick(Q);
    scl = 1'b0;
    ev(P_FALL, 1'b0);
    tick(Q);
    for (int k = 0; k < 3; k++) send_bit(rbit(), 1'b0);
    do_start(1'b0);
    send_addr(7'h67, 1'b0);
    do_stop();

    // Random frames: random address, byte count, aborted tails, repeated STARTs.
    for (int f = 0; f < 20; f++) begin
      r      = $urandom();
      addr   = r[0] ? MY_ADDR : r[7:1];
      nbytes = $urandom_range(0, 2);
      tail   = r[8] ? $urandom_range(1, 8) : 0;
      rs     = (r[10:9] == 2'b00) && (f != 19);
      do_start(1'b0);
      send_addr(addr, r[11]);
      for (int b = 0; b < nbytes; b++) begin
        r = $urandom();
        send_byte(r[7:0], 8, r[8]);
        ack_slot();
      end
      if (tail > 0) begin
        r = $urandom();
        send_byte(r[7:0], tail, r[8]);
      end
      if (!rs) do_stop();
    end
    tick(4 * Q);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout got=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
